// File: rtl/usb_spi_flash_ctrl.sv
// usb_spi_flash_ctrl: byte-level SPI mode-0 flash command engine for DFU READ/PROGRAM/ERASE4K/WAKE requests
module usb_spi_flash_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 9
) (
  input  logic             clk_48mhz,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [23:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             spi_csel,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso
);
  localparam int CW = $clog2(3 * CLK_DIV);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(3 * CLK_DIV - 1);
  typedef enum logic [3:0] {
    IDLE, WREN, GAP, OPCODE, ADDR, TX_DATA, RX_DATA, POLL_OP, POLL_RX, FINISH
  } state_t;
  state_t state, state_nxt, dst, dst_nxt;
  logic [1:0]       op_q;
  logic [23:0]      addr_q;
  logic [LEN_W-1:0] len_q, data_cnt;
  logic [1:0]       idx;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       tx_sr;
  logic [7:0]       rx_sr, load_byte, next_addr;
  logic             running, load, byte_end, last_data, needs_wren;
  function automatic logic [7:0] op_code(input logic [1:0] op);
    return op == 2'd0 ? 8'h03 : op == 2'd1 ? 8'h02 : op == 2'd2 ? 8'h20 : 8'hAB;
  endfunction
  assign byte_end   = running && spi_clk && cnt == HALF_END && bit_cnt == 3'd7;
  assign last_data  = data_cnt == len_q - LEN_W'(1);
  assign next_addr  = idx == 2'd0 ? addr_q[15:8] : addr_q[7:0];
  assign needs_wren = cmd_op == 2'd1 || cmd_op == 2'd2;
  assign cmd_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign done       = state == FINISH;
  always_comb begin
    state_nxt = state;
    dst_nxt   = dst;
    load      = 1'b0;
    load_byte = 8'h00;
    wr_ready  = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        if (!cmd_op[1] && cmd_len == '0) state_nxt = FINISH;
        else begin
          load      = 1'b1;
          state_nxt = needs_wren ? WREN : OPCODE;
          load_byte = needs_wren ? 8'h06 : op_code(cmd_op);
        end
      end
      WREN: if (byte_end) begin
        state_nxt = GAP;
        dst_nxt   = OPCODE;
      end
      // csel rises HALF_END cycles in; a further 2*CLK_DIV high cycles separate frames
      GAP: if (dst == FINISH && cnt == HALF_END) state_nxt = FINISH;
      else if (cnt == GAP_END) begin
        state_nxt = dst;
        load      = 1'b1;
        load_byte = dst == POLL_OP ? 8'h05 : op_code(op_q);
      end
      OPCODE: if (byte_end) begin
        if (op_q == 2'd3) begin
          state_nxt = GAP;
          dst_nxt   = FINISH;
        end else begin
          state_nxt = ADDR;
          load      = 1'b1;
          load_byte = addr_q[23:16];
        end
      end
      ADDR: if (byte_end) begin
        if (idx != 2'd2) begin
          load      = 1'b1;
          load_byte = next_addr;
        end else if (op_q == 2'd0) begin
          state_nxt = RX_DATA;
          load      = 1'b1;
        end else if (op_q == 2'd1) begin
          state_nxt = TX_DATA;
          wr_ready  = wr_valid;
          load      = wr_valid;
          load_byte = wr_data;
        end else begin
          state_nxt = GAP;
          dst_nxt   = POLL_OP;
        end
      end
      // without wr_valid the engine idles between bytes with clk low and csel held
      TX_DATA: if (byte_end && last_data) begin
        state_nxt = GAP;
        dst_nxt   = POLL_OP;
      end else if (byte_end || !running) begin
        wr_ready  = wr_valid;
        load      = wr_valid;
        load_byte = wr_data;
      end
      RX_DATA: if (byte_end) begin
        if (last_data) begin
          state_nxt = GAP;
          dst_nxt   = FINISH;
        end else load = 1'b1;
      end
      POLL_OP: if (byte_end) begin
        state_nxt = POLL_RX;
        load      = 1'b1;
      end
      POLL_RX: if (byte_end) begin
        if (!rx_sr[0]) begin
          state_nxt = GAP;
          dst_nxt   = FINISH;
        end else load = 1'b1;
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dst   <= IDLE;
    end else begin
      state <= state_nxt;
      dst   <= dst_nxt;
    end
  end
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      data_cnt <= '0;
      idx      <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      running  <= 1'b0;
      spi_csel <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= state == RX_DATA && byte_end;
      if (state == RX_DATA && byte_end) rd_data <= rx_sr;
      if (state == IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        data_cnt <= '0;
      end
      if (byte_end && (state == TX_DATA || state == RX_DATA)) data_cnt <= data_cnt + LEN_W'(1);
      if (byte_end) idx <= state == OPCODE ? 2'd0 : idx + 2'd1;
      if (state == GAP) cnt <= cnt + CW'(1);
      if (state == GAP && cnt == HALF_END) spi_csel <= 1'b1;
      if (load) begin
        running  <= 1'b1;
        spi_csel <= 1'b0;
        spi_clk  <= 1'b0;
        spi_mosi <= load_byte[7];
        tx_sr    <= load_byte[6:0];
        bit_cnt  <= '0;
        cnt      <= '0;
      end else if (running) begin
        cnt <= cnt == HALF_END ? '0 : cnt + CW'(1);
        if (cnt == HALF_END) begin
          spi_clk <= !spi_clk;
          if (!spi_clk) rx_sr <= {rx_sr[6:0], spi_miso};
          else if (bit_cnt == 3'd7) running <= 1'b0;
          else begin
            bit_cnt  <= bit_cnt + 3'd1;
            spi_mosi <= tx_sr[6];
            tx_sr    <= {tx_sr[5:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_spi_flash_ctrl.sv
// tb_usb_spi_flash_ctrl: directed bench with a byte-level SPI flash responder and MOSI frame log
module tb_usb_spi_flash_ctrl;
  localparam int DELIM = 'h100;
  localparam int ANY   = 'h1FF;
  logic       clk_48mhz = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, wr_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [23:0] cmd_addr = '0;
  logic [8:0] cmd_len = '0;
  logic [7:0] wr_data = '0, rd_data;
  logic       cmd_ready, wr_ready, rd_valid, busy, done, spi_csel, spi_clk, spi_mosi, spi_miso;
  int vectors = 0, errors = 0;
  logic [7:0] rsp [0:15];
  logic [6:0] fidx = '0;
  logic [7:0] sh = '0;
  int bitc = 0, sclk_edges = 0, done_cnt = 0, cs_low = 0, wrr_cnt = 0, gap_run = 0;
  int mon[$], rdq[$], gaps[$], expq[$];
  usb_spi_flash_ctrl #(.CLK_DIV(2), .LEN_W(9)) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .spi_csel(spi_csel), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );
  always #5 clk_48mhz = ~clk_48mhz;
  // flash responder: bit n of the frame is presented after n falling edges
  always @(negedge spi_clk or posedge spi_csel) fidx <= spi_csel ? 7'd0 : fidx + 7'd1;
  assign spi_miso = rsp[fidx[6:3]][3'd7 - fidx[2:0]];
  always @(posedge spi_clk or posedge spi_csel) begin
    if (spi_csel) begin
      mon.push_back(DELIM);
      bitc = 0;
    end else begin
      sclk_edges++;
      sh = {sh[6:0], spi_mosi};
      bitc++;
      if (bitc == 8) begin
        mon.push_back(int'(sh));
        bitc = 0;
      end
    end
  end
  always @(negedge clk_48mhz) begin
    if (done) done_cnt++;
    if (rd_valid) rdq.push_back(int'(rd_data));
    if (!spi_csel) cs_low++;
    if (wr_ready) wrr_cnt++;
    if (busy && spi_csel) gap_run++;
    else begin
      if (!spi_csel && gap_run > 0) gaps.push_back(gap_run);
      gap_run = 0;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_frames(input string tag, input int start);
    check({tag, "_nbytes"}, mon.size() - start, expq.size());
    foreach (expq[i])
      if (expq[i] != ANY)
        check($sformatf("%s_b%0d", tag, i), (start + i < mon.size()) ? mon[start + i] : -1, expq[i]);
  endtask
  task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [8:0] n);
    @(posedge clk_48mhz); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = n;
    @(posedge clk_48mhz); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 9'($urandom);
  endtask
  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk_48mhz); #1;
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk_48mhz);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int m0, r0, d0, c0, e0, w0, g0, n, hi_clk, hi_cs;
    for (int i = 0; i < 16; i++) rsp[i] = 8'h00;
    repeat (8) begin
      @(posedge clk_48mhz); #1;
      cmd_valid = 1'($urandom); cmd_op = 2'($urandom); cmd_addr = $urandom;
      cmd_len = 9'($urandom); wr_valid = 1'($urandom); wr_data = 8'($urandom);
    end
    check("rst_csel", spi_csel, 1);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_wrr", wr_ready, 0);
    cmd_valid = 1'b0; wr_valid = 1'b0; reset_n = 1'b1;
    e0 = sclk_edges;
    cycles(20);
    check("idle_sclk_edges", sclk_edges - e0, 0);
    // READ 0x012345, 2 bytes, with an ignored request while busy
    rsp[4] = 8'hA5; rsp[5] = 8'h3C;
    m0 = mon.size(); r0 = rdq.size(); d0 = done_cnt; c0 = cs_low;
    check("read_ready", cmd_ready, 1);
    issue(2'd0, 24'h012345, 9'd2);
    check("read_busy", busy, 1);
    cycles(60);
    cmd_valid = 1'b1; cmd_op = 2'd3;
    cycles(1);
    cmd_valid = 1'b0;
    wait_idle("read", 1000);
    cycles(80);
    expq = {32'h03, 32'h01, 32'h23, 32'h45, ANY, ANY, DELIM};
    check_frames("read", m0);
    check("read_nrd", rdq.size() - r0, 2);
    check("read_rd0", (rdq.size() > r0) ? rdq[r0] : -1, 'hA5);
    check("read_rd1", (rdq.size() > r0 + 1) ? rdq[r0 + 1] : -1, 'h3C);
    check("read_done", done_cnt - d0, 1);
    check("read_cs_low", (cs_low - c0 >= 188 && cs_low - c0 <= 196) ? 192 : cs_low - c0, 192);
    // PROGRAM 0x000100, 1 byte, data withheld, status 01,01,00
    for (int i = 0; i < 16; i++) rsp[i] = 8'h00;
    rsp[1] = 8'h01; rsp[2] = 8'h01;
    m0 = mon.size(); r0 = rdq.size(); d0 = done_cnt; w0 = wrr_cnt;
    wr_data = 8'hDD;
    issue(2'd1, 24'h000100, 9'd1);
    cycles(199);
    hi_clk = 0; hi_cs = 0;
    repeat (100) begin
      @(negedge clk_48mhz);
      if (spi_clk) hi_clk++;
      if (spi_csel) hi_cs++;
    end
    check("stall_sclk_high", hi_clk, 0);
    check("stall_csel_high", hi_cs, 0);
    check("stall_nbytes", mon.size() - m0, 6);
    check("stall_wrr", wrr_cnt - w0, 0);
    @(posedge clk_48mhz); #1;
    wr_valid = 1'b1;
    #1;
    n = 0;
    while (!wr_ready && n < 50) begin
      @(posedge clk_48mhz); #1;
      n++;
    end
    check("prog_wr_ready", wr_ready, 1);
    @(posedge clk_48mhz); #1;
    wr_valid = 1'b0;
    wait_idle("prog", 3000);
    cycles(20);
    expq = {32'h06, DELIM, 32'h02, 32'h00, 32'h01, 32'h00, 32'hDD, DELIM, 32'h05, ANY, ANY, ANY, DELIM};
    check_frames("prog", m0);
    check("prog_done", done_cnt - d0, 1);
    check("prog_wrr_pulses", wrr_cnt - w0, 1);
    check("prog_no_rdv", rdq.size() - r0, 0);
    // ERASE4K 0x001000, status 00
    for (int i = 0; i < 16; i++) rsp[i] = 8'h00;
    m0 = mon.size(); r0 = rdq.size(); d0 = done_cnt; g0 = gaps.size();
    issue(2'd2, 24'h001000, 9'd5);
    wait_idle("erase", 2000);
    cycles(20);
    expq = {32'h06, DELIM, 32'h20, 32'h00, 32'h10, 32'h00, DELIM, 32'h05, ANY, DELIM};
    check_frames("erase", m0);
    check("erase_done", done_cnt - d0, 1);
    check("erase_no_rdv", rdq.size() - r0, 0);
    check("erase_ngaps", gaps.size() - g0, 2);
    for (int i = 0; i < 2; i++)
      if (gaps.size() > g0 + i)
        check($sformatf("erase_gap%0d", i), gaps[g0 + i] >= 4 ? 4 : gaps[g0 + i], 4);
    // zero-length READ, with a WAKE pulse while busy
    d0 = done_cnt; c0 = cs_low; e0 = sclk_edges;
    check("zero_ready", cmd_ready, 1);
    @(posedge clk_48mhz); #1;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 9'd0;
    @(posedge clk_48mhz); #1;
    cmd_op = 2'd3;
    check("zero_done", done, 1);
    check("zero_busy", busy, 1);
    check("zero_not_ready", cmd_ready, 0);
    @(posedge clk_48mhz); #1;
    cmd_valid = 1'b0;
    check("zero_done_end", done, 0);
    check("zero_back_ready", cmd_ready, 1);
    cycles(40);
    check("zero_cs_low", cs_low - c0, 0);
    check("zero_sclk_edges", sclk_edges - e0, 0);
    check("zero_done_cnt", done_cnt - d0, 1);
    // reset during the address phase
    d0 = done_cnt;
    issue(2'd0, 24'hABCDEF, 9'd4);
    cycles(40);
    n = 0;
    while (!spi_clk && n < 20) begin
      @(posedge clk_48mhz); #1;
      n++;
    end
    check("arst_pre_sclk", spi_clk, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_csel", spi_csel, 1);
    check("arst_sclk", spi_clk, 0);
    check("arst_busy", busy, 0);
    cycles(3);
    reset_n = 1'b1;
    cycles(50);
    check("arst_done", done_cnt - d0, 0);
    check("arst_ready", cmd_ready, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
